// File: rtl/jisp_transpose.sv
// Ping-pong 8x8 block transpose with level shift: rows in from the MCU buffer,
// signed columns out to the DCT column pass, valid/hold handshake on both sides.
module jisp_transpose #(
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0][DW-1:0]   di,
    input  logic                 di_valid,
    output logic                 di_hold,
    input  logic [2:0]           di_cnt,
    output logic [7:0][DW-1:0]   q,
    output logic                 q_valid,
    input  logic                 q_hold,
    output logic [2:0]           q_cnt,
    output logic                 seq_err
);

    localparam int unsigned N = 8;
    localparam logic [DW-1:0] SIGN_FLIP = DW'(1) << (DW - 1);

    // bank[b][row][col]
    logic [1:0][N-1:0][N-1:0][DW-1:0] bank_q, bank_d;

    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [2:0]           wr_row_q, wr_row_d;
    logic [2:0]           rd_col_q, rd_col_d;
    logic                 seq_err_q, seq_err_d;
    logic                 di_hold_q, di_hold_d;
    logic                 q_valid_q, q_valid_d;
    logic [2:0]           q_cnt_q, q_cnt_d;
    logic [N-1:0][DW-1:0] q_q, q_d;

    logic wr_acc_c;
    logic rd_acc_c;

    assign wr_acc_c = di_valid & ~di_hold_q;
    assign rd_acc_c = q_valid_q & ~q_hold;

    // Bank pointers, fill flags and storage update
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        seq_err_d = seq_err_q;

        if (wr_acc_c) begin
            bank_d[wr_bank_q][wr_row_q] = di;
            wr_row_d = wr_row_q + 3'd1;
            if (di_cnt != wr_row_q) begin
                seq_err_d = 1'b1;
            end
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Write and read never target the same bank in one cycle
        if (rd_acc_c) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // Outputs registered from next state so they equal a decode of the state flops
    always_comb begin
        di_hold_d = full_d[wr_bank_d];
        q_valid_d = full_d[rd_bank_d];
        q_cnt_d   = rd_col_d;
        q_d       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            q_d[3'(k)] = bank_d[rd_bank_d][3'(k)][rd_col_d] ^ SIGN_FLIP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
            seq_err_q <= 1'b0;
            di_hold_q <= 1'b0;
            q_valid_q <= 1'b0;
            q_cnt_q   <= '0;
            q_q       <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
            seq_err_q <= seq_err_d;
            di_hold_q <= di_hold_d;
            q_valid_q <= q_valid_d;
            q_cnt_q   <= q_cnt_d;
            q_q       <= q_d;
        end
    end

    // Pixel storage survives reset; partial blocks are simply overwritten
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign di_hold = di_hold_q;
    assign q_valid = q_valid_q;
    assign q_cnt   = q_cnt_q;
    assign q       = q_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_jisp_transpose.sv
// Self-checking bench for jisp_transpose: block-level reference model with a
// queue of expected output columns built from accepted rows.
module tb_jisp_transpose;

    localparam int unsigned DW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0][DW-1:0] di;
    logic               di_valid;
    logic               di_hold;
    logic [2:0]         di_cnt;
    logic [7:0][DW-1:0] q;
    logic               q_valid;
    logic               q_hold;
    logic [2:0]         q_cnt;
    logic               seq_err;

    jisp_transpose #(.DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .di       (di),
        .di_valid (di_valid),
        .di_hold  (di_hold),
        .di_cnt   (di_cnt),
        .q        (q),
        .q_valid  (q_valid),
        .q_hold   (q_hold),
        .q_cnt    (q_cnt),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  part [8][8];
    int          part_rows = 0;
    logic [63:0] colq [$];
    int          cntq [$];
    bit          m_seq = 1'b0;
    int          rows_in = 0;

    function automatic bit exp_hold();
        return ((colq.size() + 7) / 8) >= 2;
    endfunction

    task automatic model_clear();
        part_rows = 0;
        colq.delete();
        cntq.delete();
        m_seq = 1'b0;
    endtask

    // One clock: note handshakes, step the model, then settle past the edge
    task automatic advance();
        bit          wacc, racc;
        logic [63:0] col;
        wacc = di_valid && !di_hold;
        racc = q_valid && !q_hold;
        @(posedge clk);
        if (racc && colq.size() > 0) begin
            void'(colq.pop_front());
            void'(cntq.pop_front());
        end
        if (wacc) begin
            rows_in++;
            if (int'(di_cnt) != part_rows) m_seq = 1'b1;
            for (int k = 0; k < 8; k++) part[part_rows][k] = di[k];
            part_rows++;
            if (part_rows == 8) begin
                for (int c = 0; c < 8; c++) begin
                    for (int k = 0; k < 8; k++) col[k*8 +: 8] = 8'(int'(part[k][c]) - 128);
                    colq.push_back(col);
                    cntq.push_back(c);
                end
                part_rows = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; di_valid = 1'b0; di_cnt = '0; di = '0; q_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (di_hold !== 1'b0) begin n_err++; $display("FAIL reset_di_hold: got %b want 0", di_hold); end
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
        n_vec++; if (q_cnt !== 3'd0) begin n_err++; $display("FAIL reset_q_cnt: got %0d want 0", q_cnt); end
        n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
        reset = 1'b0;
        model_clear();
        advance();
        n_vec++; if (q_valid !== 1'b0 || di_hold !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: q_valid %b di_hold %b want 0 0", q_valid, di_hold);
        end
    endtask

    task automatic test_single_block();
        logic [63:0] e;
        q_hold = 1'b0;
        for (int r = 0; r < 8; r++) begin
            di_valid = 1'b1; di_cnt = 3'(r);
            for (int k = 0; k < 8; k++) di[k] = 8'(8 * r + k);
            n_vec++; if (q_valid !== 1'b0 || di_hold !== 1'b0) begin
                n_err++; $display("FAIL single_fill r%0d: q_valid %b di_hold %b want 0 0", r, q_valid, di_hold);
            end
            advance();
        end
        di_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) e[k*8 +: 8] = 8'(8 * k + c - 128);
            n_vec++; if (q_valid !== 1'b1) begin n_err++; $display("FAIL single_q_valid c%0d: got %b want 1", c, q_valid); end
            n_vec++; if (q_cnt !== 3'(c)) begin n_err++; $display("FAIL single_q_cnt: got %0d want %0d", q_cnt, c); end
            n_vec++; if (q !== e) begin n_err++; $display("FAIL single_q c%0d: got %h want %h", c, q, e); end
            n_vec++; if (di_hold !== 1'b0) begin n_err++; $display("FAIL single_di_hold c%0d: got %b want 0", c, di_hold); end
            advance();
        end
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL single_q_valid_end: got %b want 0", q_valid); end
    endtask

    task automatic test_back_to_back();
        bit ev;
        q_hold = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            di_valid = (cyc < 32);
            di_cnt = 3'(part_rows);
            di = {$urandom, $urandom};
            advance();
            ev = (cyc >= 7 && cyc <= 38);
            n_vec++; if (q_valid !== ev) begin n_err++; $display("FAIL b2b_q_valid cyc%0d: got %b want %b", cyc, q_valid, ev); end
            n_vec++; if (di_hold !== 1'b0) begin n_err++; $display("FAIL b2b_di_hold cyc%0d: got %b want 0", cyc, di_hold); end
            if (q_valid && colq.size() > 0) begin
                n_vec++; if (q !== colq[0] || int'(q_cnt) != cntq[0]) begin
                    n_err++; $display("FAIL b2b_q cyc%0d: got %h/%0d want %h/%0d", cyc, q, q_cnt, colq[0], cntq[0]);
                end
            end
        end
    endtask

    task automatic test_hold_full();
        int start, guard;
        start = rows_in;
        q_hold = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            di_valid = 1'b1; di_cnt = 3'(part_rows); di = {$urandom, $urandom};
            advance();
            n_vec++; if (di_hold !== exp_hold()) begin n_err++; $display("FAIL hold_di_hold cyc%0d: got %b want %b", cyc, di_hold, exp_hold()); end
            n_vec++; if (q_valid !== (colq.size() > 0)) begin n_err++; $display("FAIL hold_q_valid cyc%0d: got %b want %b", cyc, q_valid, colq.size() > 0); end
            if (q_valid && colq.size() > 0) begin
                n_vec++; if (q !== colq[0] || q_cnt !== 3'd0) begin
                    n_err++; $display("FAIL hold_q cyc%0d: got %h/%0d want %h/0", cyc, q, q_cnt, colq[0]);
                end
            end
        end
        n_vec++; if (rows_in - start != 16 || di_hold !== 1'b1) begin
            n_err++; $display("FAIL hold_saturate: rows %0d di_hold %b want 16 1", rows_in - start, di_hold);
        end
        q_hold = 1'b0;
        for (guard = 0; guard < 100 && !(rows_in - start >= 24 && colq.size() == 0); guard++) begin
            di_valid = (rows_in - start < 24); di_cnt = 3'(part_rows); di = {$urandom, $urandom};
            advance();
            n_vec++; if (di_hold !== exp_hold()) begin n_err++; $display("FAIL release_di_hold: got %b want %b", di_hold, exp_hold()); end
            n_vec++; if (q_valid !== (colq.size() > 0)) begin n_err++; $display("FAIL release_q_valid: got %b want %b", q_valid, colq.size() > 0); end
            if (q_valid && colq.size() > 0) begin
                n_vec++; if (q !== colq[0] || int'(q_cnt) != cntq[0]) begin
                    n_err++; $display("FAIL release_q: got %h/%0d want %h/%0d", q, q_cnt, colq[0], cntq[0]);
                end
            end
        end
        di_valid = 1'b0;
        n_vec++; if (guard >= 100) begin n_err++; $display("FAIL release_timeout: got %0d cycles want < 100", guard); end
    endtask

    task automatic test_random();
        int start, guard;
        logic [63:0] prev_q;
        bit prev_stall;
        start = rows_in;
        prev_stall = 1'b0;
        prev_q = '0;
        for (guard = 0; guard < 20000 && !(rows_in - start >= 800 && colq.size() == 0); guard++) begin
            di_valid = (rows_in - start < 800) && ($urandom_range(0, 3) != 0);
            di_cnt = 3'(part_rows);
            di = {$urandom, $urandom};
            q_hold = ($urandom_range(0, 2) == 0);
            prev_stall = q_valid && q_hold;
            prev_q = q;
            advance();
            n_vec++; if (q_valid !== (colq.size() > 0)) begin n_err++; $display("FAIL rnd_q_valid: got %b want %b", q_valid, colq.size() > 0); end
            n_vec++; if (di_hold !== exp_hold()) begin n_err++; $display("FAIL rnd_di_hold: got %b want %b", di_hold, exp_hold()); end
            n_vec++; if (seq_err !== m_seq) begin n_err++; $display("FAIL rnd_seq_err: got %b want %b", seq_err, m_seq); end
            if (q_valid && colq.size() > 0) begin
                n_vec++; if (q !== colq[0] || int'(q_cnt) != cntq[0]) begin
                    n_err++; $display("FAIL rnd_q: got %h/%0d want %h/%0d", q, q_cnt, colq[0], cntq[0]);
                end
            end
            if (prev_stall) begin
                n_vec++; if (q !== prev_q) begin n_err++; $display("FAIL rnd_q_stable: got %h want %h", q, prev_q); end
            end
        end
        q_hold = 1'b0; di_valid = 1'b0;
        n_vec++; if (guard >= 20000) begin n_err++; $display("FAIL rnd_timeout: got %0d cycles want < 20000", guard); end
    endtask

    task automatic test_seq_err();
        int cnts [8] = '{0, 1, 2, 4, 5, 6, 7, 0};
        q_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            di_valid = 1'b1; di_cnt = 3'(cnts[i]); di = {$urandom, $urandom};
            advance();
            n_vec++; if (seq_err !== (i >= 3)) begin n_err++; $display("FAIL seq_err row%0d: got %b want %b", i, seq_err, i >= 3); end
        end
        di_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_vec++; if (q_valid !== 1'b1 || colq.size() == 0 || q !== colq[0]) begin
                n_err++; $display("FAIL seq_data c%0d: got %b/%h want 1/%h", c, q_valid, q, (colq.size() > 0) ? colq[0] : 64'h0);
            end
            advance();
        end
        n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_err_sticky: got %b want 1", seq_err); end
    endtask

    task automatic test_reset_mid();
        q_hold = 1'b0;
        for (int i = 0; i < 13; i++) begin
            di_valid = 1'b1; di_cnt = 3'(part_rows); di = {$urandom, $urandom};
            advance();
        end
        di_valid = 1'b0;
        n_vec++; if (q_valid !== 1'b1 || q_cnt !== 3'd5) begin
            n_err++; $display("FAIL mid_state: q_valid %b q_cnt %0d want 1 5", q_valid, q_cnt);
        end
        reset = 1'b1;
        #1;
        n_vec++; if (di_hold !== 1'b0) begin n_err++; $display("FAIL mid_rst_di_hold: got %b want 0", di_hold); end
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_q_valid: got %b want 0", q_valid); end
        n_vec++; if (q_cnt !== 3'd0) begin n_err++; $display("FAIL mid_rst_q_cnt: got %0d want 0", q_cnt); end
        n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_seq_err: got %b want 0", seq_err); end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            di_valid = 1'b1; di_cnt = 3'(r); di = {$urandom, $urandom};
            n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL mid_refill r%0d: got %b want 0", r, q_valid); end
            advance();
        end
        di_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_vec++; if (q_valid !== 1'b1 || q_cnt !== 3'(c) || colq.size() == 0 || q !== colq[0]) begin
                n_err++; $display("FAIL mid_out c%0d: got %b/%0d/%h want 1/%0d/%h", c, q_valid, q_cnt, q, c, (colq.size() > 0) ? colq[0] : 64'h0);
            end
            advance();
        end
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL mid_end_q_valid: got %b want 0", q_valid); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_hold_full();
        test_random();
        test_seq_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jisp_transpose.md
# jisp_transpose

Ping-pong 8x8 block transpose and level-shift stage directly downstream of the MCU buffer in the JPEG ISP path. It accepts one 8-pixel row per beat from the MCU buffer, with its row index, and stores complete 8x8 blocks in two alternating register banks. It emits each block column by column as signed, level-shifted samples for the column pass of the DCT. Back-pressure is carried both ways with valid/hold handshakes.

## Interface
- DW, 8, sample width; input unsigned, output signed two's complement
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- di[7:0]  in  8xDW  one block row, element k = pixel column k, unsigned
- di_valid  in  1  di/di_cnt valid
- di_hold  out  1  stall to MCU buffer; row accepted when di_valid && !di_hold
- di_cnt  in  3  row index of di within block (0..7)
- q[7:0]  out  8xDW  one block column, element k = row k, signed (pixel - 2^(DW-1))
- q_valid  out  1  q/q_cnt valid
- q_hold  in  1  stall from DCT; column accepted when q_valid && !q_hold
- q_cnt  out  3  column index of q within block (0..7)
- seq_err  out  1  sticky: accepted di_cnt differed from expected row

## Operation
- State: bank0/bank1 (64xDW each), full[1:0], wr_bank, rd_bank, wr_row[2:0], rd_col[2:0], seq_err.
- Write: on accept, bank[wr_bank][wr_row][k] <= di[k] for k=0..7 (stored raw); wr_row++.
- Accept with wr_row==7: wr_row wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Expected row is wr_row; on accept with di_cnt != wr_row, seq_err <= 1; data still stored at wr_row (di_cnt never re-indexes storage). Only reset clears seq_err.
- Read: q[k] = bank[rd_bank][k][rd_col] with MSB inverted (equivalent to subtracting 2^(DW-1)); q_cnt = rd_col.
- On accept, rd_col++; accept with rd_col==7: rd_col wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- di_hold = full[wr_bank]; q_valid = full[rd_bank]. Both are decoded from registers only; no combinational path from di_valid or q_hold.
- Same-cycle events:
  - Final row into bank A and final column out of bank B: both complete; full[A] set, full[B] cleared.
  - Final column out of bank X with no write pending: full[X] clears; di_hold deasserts next cycle if wr_bank==X.
- Full: both banks full -> di_hold=1 until a bank drains.
- Empty: q_valid=0. q and q_cnt are don't-care but must not be X after reset; q is driven from bank contents.
- While q_valid && q_hold: q and q_cnt hold stable.
- Reset (any time, including mid-block): full=0, wr_bank=rd_bank=0, wr_row=rd_col=0, seq_err=0. Partial blocks are discarded; bank data is not cleared.

## Timing
- Reset values: di_hold=0, q_valid=0, q_cnt=0, seq_err=0.
- Latency: a block's column 0 is valid the cycle after its row 7 is accepted (1 clock).
- Throughput: sustained one row in and one column out per cycle with no bubbles when q_hold=0. Per bank cycle: 8 in, 8 out.
- The first block fills in 8 cycles. di_hold first asserts only if the second block completes before the first drains.
- seq_err asserts the cycle after the offending accept.

## Test plan
- Single block, rows r with di[k] = 8r+k, di_cnt=r, q_hold=0 -> q_valid rises the cycle after row 7; column c shows q[k] = (8k+c)-128 over cycles 9..16; di_hold stays 0.
- Continuous 4 blocks back-to-back, q_hold=0 -> 32 columns out with q_valid continuous from cycle 9; di_hold never asserts; blocks emitted in order.
- q_hold=1 held throughout, 3 blocks offered -> after 16 accepts di_hold=1 and stays 1; q stays at column 0 of block 0. Release q_hold -> di_hold drops the cycle after column 7 of block 0 is accepted.
- Random q_hold and di_valid toggling over 100 blocks -> output matches transposed, level-shifted reference; q is stable whenever q_valid && q_hold.
- di_cnt sequence 0,1,2,4,... -> seq_err=1 one cycle after the row-3 accept and stays high; data is still written in arrival order.
- Assert reset after 5 rows of block 1 while block 0 is half-read -> all outputs return to reset values. A following full block emerges correctly with column 0 one cycle after its row 7.
